vector_register_file: RTL and testbench
=======================================

Name: vector_register_file

Overview:
- Vector register file for the SIMD AES datapath, in the decode stage.
- Holds eight N-bit vector registers $v0..$v7, addressed as 10000..10111 in the shared 5-bit register address space.
- Two combinational read ports feed the operand path; one synchronous write port is driven from writeback (WA3W/ResultW/RegWriteW).

Parameters:
- N, 256, width of each vector register and of the read/write data ports.

Ports:
- clk  input  1  system clock; the write port samples on its rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all registers.
- VA1  input  5  read address, port 1 (RA1D).
- VA2  input  5  read address, port 2 (RA2D).
- VA3  input  5  write address (WA3W).
- VWD3  input  N  write data (ResultW).
- VWE3  input  1  write enable (RegWriteW), active-high.
- VRD1  output  N  read data, port 1.
- VRD2  output  N  read data, port 2.

Behaviour:
- Storage is reg_array_vector[0:7], each N bits. The name is fixed so benches can probe it hierarchically.
- Address decode:
  - An address is valid when bit4 = 1; bits[2:0] select the register index.
  - bit3 = 1 (11000..11111) is invalid.
  - Any address with bit4 = 0 is invalid; these are scalar-space addresses such as 01011.
- Reset:
  - While rst = 0, all eight registers are forced to 0 asynchronously.
  - Write attempts during reset are ignored.
  - Deassertion is a plain release; registers are usable from the next rising edge.
  - Reset asserted mid-write wins; the register ends at 0.
- Write:
  - On the rising clk edge, if rst = 1, VWE3 = 1 and VA3 is valid, then reg[VA3[2:0]] <= VWD3.
  - Otherwise all registers hold.
  - Writes to invalid addresses are silently dropped.
- Read:
  - Purely combinational; zero-cycle latency from VA1/VA2 to VRD1/VRD2.
  - VRDx = reg[VAx[2:0]] when VAx is valid, else all-zero.
  - Both ports may read the same register simultaneously.
- Outputs during reset read 0 for every address.
- Same-cycle read/write of the same register:
  - Without the optional feature, a read returns the old value until the clock edge, then the new value.
- Write latency: one edge. Data written at edge k is visible combinationally immediately after edge k.
- No X propagation: every output bit is driven from defined state at all times.

Optional Feature:
- Macro: VREG_WRITE_BYPASS_EN.
- Defined:
  - If VWE3 = 1, rst = 1, VA3 is valid and VA3 == VAx, then VRDx = VWD3 combinationally in the same cycle (write-through forwarding).
  - Applies to each port independently.
  - An invalid address still reads 0.
- Undefined: no forwarding; reads reflect stored contents only.

Decomposition:
- Shared package vreg_pkg:
  - NUM_VREGS = 8.
  - VREG_ADDR_W = 5.
  - VREG_IDX_W = 3.
  - VREG_SPACE_BIT = 4.
  - Function is_vreg_addr(addr), returning valid when bit4 = 1 and bit3 = 0.
  - Typedef vreg_idx_t.
- One sub-module, vreg_addr_decode:
  - Input: 5-bit address.
  - Outputs: valid flag and 3-bit index.
  - Instantiated three times (VA1, VA2, VA3).

Test Plan:
- Reset: pulse rst = 0, then release. All reg_array_vector = 0; VA1 = 10000 and VA2 = 10111 both read 0.
- Write gated off: VA3 = 10110, VWD3 = 0x36, VWE3 = 0, clock edge. $v6 stays 0; VA1 = 10110 reads 0.
- Write: VA3 = 10110, VWD3 = 0x55, VWE3 = 1, edge. $v6 = 0x55, and the next read of VA1 = 10110 gives 0x55. Then VWD3 = 0xCC, VWE3 = 1, edge: VA2 = 10110 reads 0xCC, while VA1 = 10010 reads 0.
- Dual read: $v0 = 0x0C and $v6 = 0xCC preloaded; VA1 = 10000, VA2 = 10110. VRD1 = 0x0C and VRD2 = 0xCC in the same cycle.
- Invalid addresses:
  - VA1 = 01011 and VA2 = 01001 both read 0.
  - VA3 = 01011, VWE3 = 1, VWD3 = all-ones: no register changes.
  - VA3 = 11000 with the same data: no register changes.
- Async reset mid-operation: $v3 = 0xABCD, drop rst between edges. $v3 reads 0 immediately, without waiting for a clock edge. With VREG_WRITE_BYPASS_EN defined: VA3 = VA1 = 10011, VWE3 = 1, VWD3 = 0x77 gives VRD1 = 0x77 before the edge.

Source files
------------

// File: rtl/vreg_pkg.sv
// Shared constants, index type and address-space helper for the vector register file.
package vreg_pkg;

  localparam int unsigned NUM_VREGS      = 8;
  localparam int unsigned VREG_ADDR_W    = 5;
  localparam int unsigned VREG_IDX_W     = 3;
  localparam int unsigned VREG_SPACE_BIT = 4;

  typedef logic [VREG_IDX_W-1:0] vreg_idx_t;

  // Vector space is 10000..10111; bit3 set or bit4 clear falls outside it.
  function automatic logic is_vreg_addr(input logic [VREG_ADDR_W-1:0] addr);
    return addr[VREG_SPACE_BIT] & ~addr[VREG_SPACE_BIT-1];
  endfunction

endpackage

// File: rtl/vreg_addr_decode.sv
// Combinational decode of a 5-bit register address into vector valid flag and index.
module vreg_addr_decode
  import vreg_pkg::*;
(
  input  logic [VREG_ADDR_W-1:0] addr_i,
  output logic                   valid_c_o,
  output vreg_idx_t              idx_c_o
);

  assign valid_c_o = is_vreg_addr(addr_i);
  assign idx_c_o   = vreg_idx_t'(addr_i[VREG_IDX_W-1:0]);

endmodule

// File: rtl/vector_register_file.sv
// Eight-entry vector register file: two combinational read ports, one synchronous write port.
// Optional same-cycle write-through forwarding is enabled by defining VREG_WRITE_BYPASS_EN.
module vector_register_file
  import vreg_pkg::*;
#(
  parameter int unsigned N = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [VREG_ADDR_W-1:0] VA1,
  input  logic [VREG_ADDR_W-1:0] VA2,
  input  logic [VREG_ADDR_W-1:0] VA3,
  input  logic [N-1:0]           VWD3,
  input  logic                   VWE3,
  output logic [N-1:0]           VRD1,
  output logic [N-1:0]           VRD2
);

  logic [N-1:0] reg_array_vector [0:NUM_VREGS-1];

  logic      rd1_valid, rd2_valid, wr_valid;
  vreg_idx_t rd1_idx, rd2_idx, wr_idx;

  vreg_addr_decode u_dec_ra1 (.addr_i(VA1), .valid_c_o(rd1_valid), .idx_c_o(rd1_idx));
  vreg_addr_decode u_dec_ra2 (.addr_i(VA2), .valid_c_o(rd2_valid), .idx_c_o(rd2_idx));
  vreg_addr_decode u_dec_wa3 (.addr_i(VA3), .valid_c_o(wr_valid),  .idx_c_o(wr_idx));

  // Storage; async clear has priority over any write in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_VREGS; i++) begin
        reg_array_vector[i] <= '0;
      end
    end else if (VWE3 && wr_valid) begin
      reg_array_vector[wr_idx] <= VWD3;
    end
  end

  // Read ports; out-of-space addresses return zero.
  always_comb begin
    VRD1 = '0;
    VRD2 = '0;
    if (rd1_valid) VRD1 = reg_array_vector[rd1_idx];
    if (rd2_valid) VRD2 = reg_array_vector[rd2_idx];
`ifdef VREG_WRITE_BYPASS_EN
    if (rst && VWE3 && wr_valid && rd1_valid && (VA3 == VA1)) VRD1 = VWD3;
    if (rst && VWE3 && wr_valid && rd2_valid && (VA3 == VA2)) VRD2 = VWD3;
`endif
  end

endmodule

// File: tb/tb_vector_register_file.sv
// Directed self-checking bench for vector_register_file (default N = 256).
module tb_vector_register_file;

  localparam int unsigned N = 256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   va1, va2, va3;
  logic [N-1:0] vwd3;
  logic         vwe3;
  logic [N-1:0] vrd1, vrd2;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [N-1:0] exp_mem [0:7];

  vector_register_file #(.N(N)) dut (
    .clk (clk),
    .rst (rst_n),
    .VA1 (va1),
    .VA2 (va2),
    .VA3 (va3),
    .VWD3(vwd3),
    .VWE3(vwe3),
    .VRD1(vrd1),
    .VRD2(vrd2)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      check_vec($sformatf("%s_v%0d", tag, i), dut.reg_array_vector[i], exp_mem[i]);
    end
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [N-1:0] data);
    va3  = addr;
    vwd3 = data;
    vwe3 = 1'b1;
    tick();
    vwe3 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
    rst_n = 1'b0;
    va1 = 5'b10000; va2 = 5'b10111; va3 = 5'b00000;
    vwd3 = '0; vwe3 = 1'b0;
    #22;

    // Reset state
    check_all_regs("reset");
    check_vec("reset_rd1_v0", vrd1, '0);
    check_vec("reset_rd2_v7", vrd2, '0);

    @(negedge clk);
    rst_n = 1'b1;

    // Write gated off
    va3 = 5'b10110; vwd3 = N'(32'h36); vwe3 = 1'b0;
    tick();
    va1 = 5'b10110; #1;
    check_vec("gated_v6", dut.reg_array_vector[6], '0);
    check_vec("gated_rd1", vrd1, '0);

    // Write then read back
    write_reg(5'b10110, N'(32'h55));
    #1;
    check_vec("wr55_v6", dut.reg_array_vector[6], N'(32'h55));
    check_vec("wr55_rd1", vrd1, N'(32'h55));

    // Same-cycle overwrite: old value before edge unless forwarding
    va3 = 5'b10110; vwd3 = N'(32'hCC); vwe3 = 1'b1; #1;
`ifdef VREG_WRITE_BYPASS_EN
    check_vec("samecyc_rd1", vrd1, N'(32'hCC));
`else
    check_vec("samecyc_rd1", vrd1, N'(32'h55));
`endif
    tick();
    vwe3 = 1'b0;
    va2 = 5'b10110; va1 = 5'b10010; #1;
    check_vec("wrCC_rd2", vrd2, N'(32'hCC));
    check_vec("wrCC_rd1_v2", vrd1, '0);
    exp_mem[6] = N'(32'hCC);

    // Dual read
    write_reg(5'b10000, N'(32'h0C));
    exp_mem[0] = N'(32'h0C);
    va1 = 5'b10000; va2 = 5'b10110; #1;
    check_vec("dual_rd1", vrd1, N'(32'h0C));
    check_vec("dual_rd2", vrd2, N'(32'hCC));
    va2 = 5'b10000; #1;
    check_vec("dual_same_rd2", vrd2, N'(32'h0C));

    // Invalid reads, with aliased registers holding nonzero data
    write_reg(5'b10011, N'(32'h33));
    write_reg(5'b10001, N'(32'h11));
    exp_mem[3] = N'(32'h33);
    exp_mem[1] = N'(32'h11);
    va1 = 5'b10011; va2 = 5'b10001; #1;
    check_vec("valid_rd1_v3", vrd1, N'(32'h33));
    check_vec("valid_rd2_v1", vrd2, N'(32'h11));
    va1 = 5'b01011; va2 = 5'b01001; #1;
    check_vec("inv_rd1_01011", vrd1, '0);
    check_vec("inv_rd2_01001", vrd2, '0);
    va1 = 5'b11011; va2 = 5'b11000; #1;
    check_vec("inv_rd1_11011", vrd1, '0);
    check_vec("inv_rd2_11000", vrd2, '0);

    // Invalid writes are dropped
    write_reg(5'b01011, '1);
    check_all_regs("invwr_01011");
    write_reg(5'b11000, '1);
    check_all_regs("invwr_11000");

    // Async reset mid-operation
    write_reg(5'b10011, N'(32'hABCD));
    va1 = 5'b10011; #1;
    check_vec("abcd_rd1", vrd1, N'(32'hABCD));
    rst_n = 1'b0; #1;
    check_vec("async_rst_rd1", vrd1, '0);
    check_vec("async_rst_v3", dut.reg_array_vector[3], '0);
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
    // Writes while held in reset are ignored, forwarding included
    va3 = 5'b10011; vwd3 = N'(32'h77); vwe3 = 1'b1; #1;
    check_vec("rst_nofwd_rd1", vrd1, '0);
    tick();
    check_all_regs("rst_wr");
    vwe3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Forwarding (or its absence) before the edge
    va3 = 5'b10011; va1 = 5'b10011; va2 = 5'b10000;
    vwd3 = N'(32'h77); vwe3 = 1'b1; #1;
`ifdef VREG_WRITE_BYPASS_EN
    check_vec("fwd_rd1", vrd1, N'(32'h77));
`else
    check_vec("fwd_rd1", vrd1, '0);
`endif
    check_vec("fwd_rd2_other", vrd2, '0);
    tick();
    vwe3 = 1'b0; #1;
    check_vec("post_fwd_rd1", vrd1, N'(32'h77));

    // Forwarding on port 2 independently
    va2 = 5'b10011; va1 = 5'b10000; vwd3 = N'(32'h99); vwe3 = 1'b1; #1;
`ifdef VREG_WRITE_BYPASS_EN
    check_vec("fwd_rd2", vrd2, N'(32'h99));
`else
    check_vec("fwd_rd2", vrd2, N'(32'h77));
`endif
    check_vec("fwd_rd1_other", vrd1, '0);
    vwe3 = 1'b0;
    tick();

    // Invalid address never forwards
    va3 = 5'b11011; va1 = 5'b11011; vwd3 = '1; vwe3 = 1'b1; #1;
    check_vec("inv_fwd_rd1", vrd1, '0);
    tick();
    vwe3 = 1'b0;
    exp_mem[3] = N'(32'h77);
    check_all_regs("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
